arb_req_stage: RTL and testbench

ARB_REQ_STAGE -- requirements
Module: arb_req_stage

---
 rtl/arb_req_pkg.sv | 6 +
 rtl/arb_req_slot.sv | 23 ++
 rtl/arb_req_stage.sv | 69 ++++++
 tb/tb_arb_req_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/arb_req_pkg.sv
// arb_req_pkg: state encoding and default sizing shared by the arbiter request stage
package arb_req_pkg;
  localparam int NUM_PORTS_DEF = 4;
  localparam int DATA_W_DEF = 8;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/arb_req_slot.sv
// arb_req_slot: one-entry pending payload holder (in_valid/in_data capture, clr frees, pending/data out)
module arb_req_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr,
  output logic              pending,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge clk)
    if (reset) begin
      pending <= 1'b0;
      data <= '0;
    end else if (in_valid && !pending) begin
      pending <= 1'b1;
      data <= in_data;
    end else if (clr) begin
      pending <= 1'b0;
    end
endmodule

// File: rtl/arb_req_stage.sv
// arb_req_stage: per-port slots feeding an external arbiter via req_o/gnt_i, granted payload out via out_valid/out_ready, sticky err_o, saturating xfer_cnt_o
module arb_req_stage import arb_req_pkg::*; #(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int PW = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             in_valid_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] in_data_i,
  output logic [NUM_PORTS-1:0]             in_ready_o,
  output logic [NUM_PORTS-1:0]             req_o,
  input  logic [NUM_PORTS-1:0]             gnt_i,
  output logic                             out_valid_o,
  output logic [DATA_W-1:0]                out_data_o,
  output logic [PW-1:0]                    out_port_o,
  input  logic                             out_ready_i,
  output logic                             err_o,
  output logic [15:0]                      xfer_cnt_o
);
  state_t state, state_nx;
  logic [NUM_PORTS-1:0] pending, clr;
  logic [DATA_W-1:0] slot_data [NUM_PORTS];
  logic [PW-1:0] idx;
  logic one_hot, gnt_ok, gnt_bad;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
    arb_req_slot #(.DATA_W(DATA_W)) u_slot (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid_i[g]),
      .in_data(in_data_i[g]),
      .clr(clr[g]),
      .pending(pending[g]),
      .data(slot_data[g])
    );
  end
  assign one_hot = (gnt_i != '0) && ((gnt_i & (gnt_i - NUM_PORTS'(1))) == '0);
  assign gnt_ok = (state == IDLE) && one_hot && ((gnt_i & ~pending) == '0);
  assign gnt_bad = (state == IDLE) && (gnt_i != '0) && !gnt_ok;
  assign clr = gnt_ok ? gnt_i : '0;
  assign in_ready_o = ~pending;
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (gnt_i[i]) idx = PW'(i);
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE) ? (gnt_ok ? SEND : IDLE) : (out_ready_i ? IDLE : SEND);
  always_comb begin
    req_o = (state == IDLE) ? pending : '0;
    out_valid_o = (state == SEND);
  end
  always_ff @(posedge clk)
    if (reset) begin
      out_data_o <= '0;
      out_port_o <= '0;
      err_o <= 1'b0;
      xfer_cnt_o <= '0;
    end else begin
      if (gnt_ok) begin
        out_data_o <= slot_data[idx];
        out_port_o <= idx;
      end
      if (gnt_bad) err_o <= 1'b1;
      if (state == SEND && out_ready_i && xfer_cnt_o != 16'hFFFF) xfer_cnt_o <= xfer_cnt_o + 16'd1;
    end
endmodule

// File: tb/tb_arb_req_stage.sv
// tb_arb_req_stage: directed scenarios against an LSB-priority arbiter model with grant override
module tb_arb_req_stage;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] in_valid_i;
  logic [3:0][7:0] in_data_i;
  logic [3:0] in_ready_o, req_o, gnt_i;
  logic out_valid_o, out_ready_i, err_o;
  logic [7:0] out_data_o;
  logic [1:0] out_port_o;
  logic [15:0] xfer_cnt_o;
  logic force_en;
  logic [3:0] force_gnt;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  always_comb gnt_i = force_en ? force_gnt : (req_o & (~req_o + 4'd1));
  arb_req_stage dut (
    .clk(clk),
    .reset(reset),
    .in_valid_i(in_valid_i),
    .in_data_i(in_data_i),
    .in_ready_o(in_ready_o),
    .req_o(req_o),
    .gnt_i(gnt_i),
    .out_valid_o(out_valid_o),
    .out_data_o(out_data_o),
    .out_port_o(out_port_o),
    .out_ready_i(out_ready_i),
    .err_o(err_o),
    .xfer_cnt_o(xfer_cnt_o)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    cyc();
    do_reset();
    cyc();
    checks++; if (in_ready_o !== 4'b1111) begin fails++; $display("FAIL reset_ready got %b exp 1111", in_ready_o); end
    checks++; if (req_o !== 4'b0000) begin fails++; $display("FAIL reset_req got %b exp 0000", req_o); end
    checks++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid_o); end
    checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err_o); end
    checks++; if (xfer_cnt_o !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", xfer_cnt_o); end
  endtask
  task automatic test_single();
    in_valid_i = 4'b0100;
    in_data_i[2] = 8'hA5;
    cyc();
    in_valid_i = '0;
    checks++; if (req_o !== 4'b0100) begin fails++; $display("FAIL single_req got %b exp 0100", req_o); end
    checks++; if (in_ready_o !== 4'b1011) begin fails++; $display("FAIL single_ready got %b exp 1011", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL single_early_valid got %b exp 0", out_valid_o); end
    cyc();
    checks++; if (out_valid_o !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", out_valid_o); end
    checks++; if (out_data_o !== 8'hA5) begin fails++; $display("FAIL single_data got %h exp a5", out_data_o); end
    checks++; if (out_port_o !== 2'd2) begin fails++; $display("FAIL single_port got %0d exp 2", out_port_o); end
    checks++; if (req_o !== 4'b0000) begin fails++; $display("FAIL single_send_req got %b exp 0000", req_o); end
    checks++; if (in_ready_o !== 4'b1111) begin fails++; $display("FAIL single_freed got %b exp 1111", in_ready_o); end
    cyc();
    checks++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL single_done_valid got %b exp 0", out_valid_o); end
    checks++; if (xfer_cnt_o !== 16'd1) begin fails++; $display("FAIL single_cnt got %0d exp 1", xfer_cnt_o); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    in_valid_i = 4'b1001;
    in_data_i[0] = 8'h11;
    in_data_i[3] = 8'h33;
    cyc();
    in_valid_i = '0;
    checks++; if (req_o !== 4'b1001) begin fails++; $display("FAIL b2b_req got %b exp 1001", req_o); end
    cyc();
    checks++; if (out_data_o !== 8'h11 || out_port_o !== 2'd0 || out_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_first got %h/%0d/%b exp 11/0/1", out_data_o, out_port_o, out_valid_o); end
    cyc();
    checks++; if (req_o !== 4'b1000 || xfer_cnt_o !== 16'd1) begin fails++; $display("FAIL b2b_mid got %b/%0d exp 1000/1", req_o, xfer_cnt_o); end
    cyc();
    checks++; if (out_data_o !== 8'h33 || out_port_o !== 2'd3 || out_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_second got %h/%0d/%b exp 33/3/1", out_data_o, out_port_o, out_valid_o); end
    cyc();
    checks++; if (xfer_cnt_o !== 16'd2 || out_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_cnt got %0d/%b exp 2/0", xfer_cnt_o, out_valid_o); end
  endtask
  task automatic test_stall();
    out_ready_i = 1'b0;
    in_valid_i = 4'b0010;
    in_data_i[1] = 8'h5C;
    cyc();
    in_valid_i = '0;
    cyc();
    in_valid_i = 4'b0001;
    in_data_i[0] = 8'h77;
    for (int i = 0; i < 5; i++) begin
      cyc();
      in_valid_i = '0;
      checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h5C || out_port_o !== 2'd1) begin fails++; $display("FAIL stall_hold[%0d] got %b/%h/%0d exp 1/5c/1", i, out_valid_o, out_data_o, out_port_o); end
      checks++; if (req_o !== 4'b0000 || in_ready_o !== 4'b1110) begin fails++; $display("FAIL stall_req[%0d] got %b/%b exp 0000/1110", i, req_o, in_ready_o); end
    end
    out_ready_i = 1'b1;
    cyc();
    checks++; if (out_valid_o !== 1'b0 || req_o !== 4'b0001 || xfer_cnt_o !== 16'd3) begin fails++; $display("FAIL stall_release got %b/%b/%0d exp 0/0001/3", out_valid_o, req_o, xfer_cnt_o); end
    cyc();
    checks++; if (out_data_o !== 8'h77 || out_port_o !== 2'd0 || out_valid_o !== 1'b1) begin fails++; $display("FAIL stall_next got %h/%0d/%b exp 77/0/1", out_data_o, out_port_o, out_valid_o); end
    cyc();
    checks++; if (xfer_cnt_o !== 16'd4) begin fails++; $display("FAIL stall_cnt got %0d exp 4", xfer_cnt_o); end
  endtask
  task automatic test_err();
    force_en = 1'b1;
    force_gnt = 4'b0000;
    in_valid_i = 4'b0011;
    in_data_i[0] = 8'h01;
    in_data_i[1] = 8'h02;
    cyc();
    in_valid_i = '0;
    checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_zero_gnt got %b exp 0", err_o); end
    force_gnt = 4'b0011;
    cyc();
    checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_set got %b exp 1", err_o); end
    checks++; if (req_o !== 4'b0011 || in_ready_o !== 4'b1100 || out_valid_o !== 1'b0) begin fails++; $display("FAIL err_hold got %b/%b/%b exp 0011/1100/0", req_o, in_ready_o, out_valid_o); end
    force_gnt = 4'b0100;
    cyc();
    checks++; if (req_o !== 4'b0011 || out_valid_o !== 1'b0) begin fails++; $display("FAIL err_nonpending got %b/%b exp 0011/0", req_o, out_valid_o); end
    force_en = 1'b0;
    cyc();
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h01 || err_o !== 1'b1) begin fails++; $display("FAIL err_sticky got %b/%h/%b exp 1/01/1", out_valid_o, out_data_o, err_o); end
    cyc();
    cyc();
    checks++; if (out_data_o !== 8'h02 || out_port_o !== 2'd1 || err_o !== 1'b1) begin fails++; $display("FAIL err_after got %h/%0d/%b exp 02/1/1", out_data_o, out_port_o, err_o); end
    cyc();
  endtask
  task automatic test_reset_send();
    do_reset();
    out_ready_i = 1'b0;
    in_valid_i = 4'b1000;
    in_data_i[3] = 8'h9E;
    cyc();
    in_valid_i = '0;
    cyc();
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h9E) begin fails++; $display("FAIL rsend_pre got %b/%h exp 1/9e", out_valid_o, out_data_o); end
    do_reset();
    checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 4'b1111 || req_o !== 4'b0000) begin fails++; $display("FAIL rsend_state got %b/%b/%b exp 0/1111/0000", out_valid_o, in_ready_o, req_o); end
    checks++; if (xfer_cnt_o !== 16'd0 || out_data_o !== 8'h00 || out_port_o !== 2'd0) begin fails++; $display("FAIL rsend_regs got %0d/%h/%0d exp 0/00/0", xfer_cnt_o, out_data_o, out_port_o); end
    out_ready_i = 1'b1;
    cyc();
    checks++; if (xfer_cnt_o !== 16'd0 || out_valid_o !== 1'b0) begin fails++; $display("FAIL rsend_after got %0d/%b exp 0/0", xfer_cnt_o, out_valid_o); end
  endtask
  initial begin
    reset = 1'b1;
    in_valid_i = '0;
    in_data_i = '0;
    out_ready_i = 1'b1;
    force_en = 1'b0;
    force_gnt = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_err();
    test_reset_send();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
